seg_scan_decoder: RTL

- Receiver for the multiplexed seven-segment bus (select + segment data) driven by the display-side logic. It recovers the digit value shown on each display position.
- Samples the scanned bus and waits for each {select, data} pair to hold stable. It then decodes the segment pattern back to a 4-bit hex value plus decimal point and holds it in per-digit registers.
- Used on-board for display readback and self-check, and as the bench monitor for every block that drives the display.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_decode.sv | 48 ++++
 rtl/seg_scan_decoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared seven-segment constants: glyph patterns for hex digits 0..F,
// segment bit positions and the blank pattern.
// Revision: 1.0
// ----------------------------------------------------------------------------
package seg7_pkg;

  // Segment bit positions within the 8-bit segment bus
  localparam int SEG_A_BIT  = 0;
  localparam int SEG_B_BIT  = 1;
  localparam int SEG_C_BIT  = 2;
  localparam int SEG_D_BIT  = 3;
  localparam int SEG_E_BIT  = 4;
  localparam int SEG_F_BIT  = 5;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  // Blank pattern (nothing lit)
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Glyph patterns, decimal point clear
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_decode
// Combinational seven-segment pattern to hex value decoder. The glyph is
// matched on segments a..g only; the decimal point is passed through.
// Revision: 1.0
// ----------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [7:0] pattern,
  output logic       hit,
  output logic [3:0] value,
  output logic       dp
);

  logic [7:0] glyph;

  assign glyph = {1'b0, pattern[SEG_G_BIT:SEG_A_BIT]};
  assign dp    = pattern[SEG_DP_BIT];

  // Match the glyph against the sixteen hex patterns
  always_comb begin
    hit   = 1'b1;
    value = 4'h0;
    case (glyph)
      SEG_0:   value = 4'h0;
      SEG_1:   value = 4'h1;
      SEG_2:   value = 4'h2;
      SEG_3:   value = 4'h3;
      SEG_4:   value = 4'h4;
      SEG_5:   value = 4'h5;
      SEG_6:   value = 4'h6;
      SEG_7:   value = 4'h7;
      SEG_8:   value = 4'h8;
      SEG_9:   value = 4'h9;
      SEG_A:   value = 4'hA;
      SEG_B:   value = 4'hB;
      SEG_C:   value = 4'hC;
      SEG_D:   value = 4'hD;
      SEG_E:   value = 4'hE;
      SEG_F:   value = 4'hF;
      default: hit   = 1'b0;
    endcase
  end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_decoder
// Receiver for a scanned seven-segment bus. Waits for each {select, data}
// pair to hold stable, decodes the glyph and keeps per-digit value, dp and
// valid registers, with frame-completion and error pulses.
// Revision: 1.0
// ----------------------------------------------------------------------------
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int                    NUM_DIGITS    = 5,
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [NUM_DIGITS-1:0] DIGIT_MASK    = 5'b11111
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [NUM_DIGITS-1:0]     seg_sel,
  input  logic [7:0]                seg_data,
  output logic [4*NUM_DIGITS-1:0]   digit_val,
  output logic [NUM_DIGITS-1:0]     digit_dp,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      frame_done,
  output logic                      code_err,
  output logic                      sel_err,
  output logic [7:0]                err_count
);

  localparam int                    SAMPLE_W = NUM_DIGITS + 8;
  localparam logic [7:0]            STABLE_N = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

  logic [SAMPLE_W-1:0]   sample;
  logic [SAMPLE_W-1:0]   s_q;
  logic [7:0]            run_q;
  logic [7:0]            run_next;
  logic                  cap_next;
  logic                  cap_q;

  logic [NUM_DIGITS-1:0] sel_q;
  logic                  sel_zero;
  logic                  sel_multi;
  logic                  dec_hit;
  logic [3:0]            dec_val;
  logic                  dec_dp;

  logic                  do_load;
  logic                  do_code_err;
  logic                  do_sel_err;
  logic [NUM_DIGITS-1:0] seen_q;
  logic [NUM_DIGITS-1:0] seen_upd;
  logic                  frame_hit;

  assign sample = {seg_sel, seg_data};

  // Run-length of identical samples; a capture is armed exactly once, on the
  // sample that brings the run up to STABLE_CYCLES
  always_comb begin
    run_next = run_q;
    if (sample != s_q) begin
      run_next = 8'd1;
    end else if (run_q != STABLE_N) begin
      run_next = run_q + 8'd1;
    end
    cap_next = (run_next == STABLE_N) && ((sample != s_q) || (run_q != STABLE_N));
  end

  // Input sample register, run counter and armed-capture flag
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s_q   <= '0;
      run_q <= 8'd0;
      cap_q <= 1'b0;
    end else begin
      s_q   <= sample;
      run_q <= run_next;
      cap_q <= cap_next;
    end
  end

  // The armed capture acts on the stable sample held in s_q
  assign sel_q     = s_q[SAMPLE_W-1:8];
  assign sel_zero  = (sel_q == '0);
  assign sel_multi = ((sel_q & (sel_q - SEL_ONE)) != '0);

  seg7_decode u_decode (
    .pattern (s_q[7:0]),
    .hit     (dec_hit),
    .value   (dec_val),
    .dp      (dec_dp)
  );

  // Classify the capture and work out frame completion
  always_comb begin
    do_load     = 1'b0;
    do_code_err = 1'b0;
    do_sel_err  = 1'b0;
    if (cap_q && !sel_zero) begin
      if (sel_multi) begin
        do_sel_err = 1'b1;
      end else if (dec_hit) begin
        do_load = 1'b1;
      end else begin
        do_code_err = 1'b1;
      end
    end
    seen_upd  = seen_q | sel_q;
    frame_hit = ((seen_upd & DIGIT_MASK) == DIGIT_MASK);
  end

  // Per-digit value/dp/valid registers; invalid glyph only drops valid
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      digit_val   <= '0;
      digit_dp    <= '0;
      digit_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_q[i] && do_load) begin
          digit_val[4*i +: 4] <= dec_val;
          digit_dp[i]         <= dec_dp;
          digit_valid[i]      <= 1'b1;
        end else if (sel_q[i] && do_code_err) begin
          digit_valid[i]      <= 1'b0;
        end
      end
    end
  end

  // Seen-set tracking and the frame-complete pulse
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      seen_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (do_load) begin
        if (frame_hit) begin
          seen_q     <= '0;
          frame_done <= 1'b1;
        end else begin
          seen_q     <= seen_upd;
        end
      end
    end
  end

  // Error pulses and the saturating error counter
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      code_err  <= 1'b0;
      sel_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      code_err <= do_code_err;
      sel_err  <= do_sel_err;
      if ((do_code_err || do_sel_err) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule : seg_scan_decoder
`default_nettype wire
